ahb_apb_bridge_mslv: RTL and testbench
======================================

Name: ahb_apb_bridge_mslv

Overview:
- Parametrised AHB-to-APB bridge. Translates single AHB transfers into APB3 transfers, with configurable address/data width and APB slave count.
- Adds behaviour the current bridge lacks:
  - per-slave PREADY wait-state stretching;
  - PSLVERR mapped to the two-cycle AHB ERROR response;
  - out-of-range decode and unsupported-size errors.
- Sits between the AHB interface agent and the APB slave ring, on the single system clock.

Parameters:
- ADDR_W, 32, AHB/APB address width.
- DATA_W, 32, data width (32 or 64).
- NUM_SLV, 4, number of APB slaves (1..16); SEL_W = max(1, clog2(NUM_SLV)).
- SLV_SEL_LSB, 28, LSB of the Haddr slice [SLV_SEL_LSB +: SEL_W] that selects the slave.

Ports:
- Hclk  in  1  system clock, rising edge.
- Hreset  in  1  asynchronous, active-high reset.
- Htrans  in  2  AHB transfer type.
- Hsize  in  3  AHB transfer size.
- Hburst  in  3  AHB burst; ignored, every beat is handled as a single.
- Hreadyin  in  1  AHB bus ready.
- Haddr  in  ADDR_W  AHB address.
- Hwrite  in  1  1 = write.
- Hwdata  in  DATA_W  AHB write data (data phase).
- Hrdata  out  DATA_W  AHB read data.
- Hresp  out  2  00 OKAY, 01 ERROR.
- Hreadyout  out  1  bridge ready.
- Paddr  out  ADDR_W  APB address.
- Pwdata  out  DATA_W  APB write data.
- Pwrite  out  1  APB direction.
- Pselx  out  NUM_SLV  one-hot slave select.
- Penable  out  1  APB access phase.
- Prdata  in  NUM_SLV*DATA_W  packed per-slave read data; slave i at [i*DATA_W +: DATA_W].
- Pready  in  NUM_SLV  per-slave ready.
- Pslverr  in  NUM_SLV  per-slave error.

Behaviour:
- Valid transfer: Hreadyin=1 and Htrans is NONSEQ (10) or SEQ (11). IDLE/BUSY are ignored and get an OKAY zero-wait response.
- Reset (async assert, sync release):
  - state IDLE;
  - Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0;
  - Hreadyout=1, Hresp=00, Hrdata=0.
- Address phase capture: Haddr, Hwrite, slave index and size-check result are registered on the edge where a valid transfer is seen in IDLE, or in ERR2.
- Decode error: index >= NUM_SLV, or Hsize > clog2(DATA_W/8). Goes to ERR1 with no APB activity.
- FSM:
  - IDLE: valid write -> WWAIT; valid read -> SETUP; decode error -> ERR1. Hreadyout=1.
  - WWAIT: Hreadyout=0; Hwdata registered into Pwdata; -> SETUP.
  - SETUP: Pselx[idx]=1, Penable=0, Paddr/Pwrite from latch, Hreadyout=0; -> ACCESS.
  - ACCESS: Pselx[idx]=1, Penable=1; Paddr, Pwrite, Pwdata held stable.
    - Pready[idx]=0: stay, Hreadyout=0.
    - Pready[idx]=1 with Pslverr[idx]=1: -> ERR1.
    - Pready[idx]=1 with Pslverr[idx]=0: Hreadyout=1, Hresp=00, Hrdata = Prdata slice (combinational) this cycle. Next state by the same rules as IDLE (back-to-back pipelined transfer), else IDLE.
  - ERR1: Hresp=01, Hreadyout=0, Pselx=0, Penable=0; -> ERR2.
  - ERR2: Hresp=01, Hreadyout=1; next state by the same rules as IDLE.
- Pselx and Penable are registered outputs; Pselx is never multi-hot.
- Hrdata is 0 outside the ACCESS completion cycle.
- Latency, no APB waits: read = 2 cycles from address phase to Hreadyout=1; write = 3 cycles.
- Each Pready=0 cycle adds exactly 1 cycle.
- Reset mid-transfer: immediate return to reset values. No APB transfer completes, and Pselx drops asynchronously.

Test Plan:
- Read, slave 2, Haddr=0x2000_0010, Prdata slice 2=0xCAFE_F00D, Pready=1 -> Pselx=0100 for 2 cycles, Penable in 2nd; Hreadyout=1 with Hrdata=0xCAFE_F00D 2 cycles after address phase; Hresp=00.
- Write, slave 1, Haddr=0x1000_0004, Hwdata=0xA5A5_5A5A, Pready held 0 for 3 cycles -> Pwdata=0xA5A5_5A5A stable through ACCESS; Hreadyout low for 2+3 cycles, high on 6th.
- Slave 3 returns Pready=1, Pslverr=1 -> Hresp=01 with Hreadyout=0 then Hresp=01 with Hreadyout=1; Pselx=0 in both cycles.
- NUM_SLV=3, Haddr=0x3000_0000; then separately Hsize=011 with DATA_W=32 -> two-cycle ERROR, no Pselx pulse.
- Back-to-back: read slave 0 completing in the same cycle a NONSEQ write to slave 1 is presented -> write enters WWAIT next cycle; no IDLE gap; both complete OKAY.
- Assert Hreset during ACCESS with Pready=0 -> Pselx, Penable, Hresp go to 0 and Hreadyout to 1 before the next edge; after release a new read completes normally.

Source files
------------

// File: rtl/ahb_apb_bridge_mslv.sv
// ahb_apb_bridge_mslv: AHB single-transfer to APB3 bridge with wait states and error responses
module ahb_apb_bridge_mslv #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_SLV     = 4,
  parameter int SLV_SEL_LSB = 28
) (
  input  logic                      Hclk,
  input  logic                      Hreset,
  input  logic [1:0]                Htrans,
  input  logic [2:0]                Hsize,
  input  logic [2:0]                Hburst,
  input  logic                      Hreadyin,
  input  logic [ADDR_W-1:0]         Haddr,
  input  logic                      Hwrite,
  input  logic [DATA_W-1:0]         Hwdata,
  output logic [DATA_W-1:0]         Hrdata,
  output logic [1:0]                Hresp,
  output logic                      Hreadyout,
  output logic [ADDR_W-1:0]         Paddr,
  output logic [DATA_W-1:0]         Pwdata,
  output logic                      Pwrite,
  output logic [NUM_SLV-1:0]        Pselx,
  output logic                      Penable,
  input  logic [NUM_SLV*DATA_W-1:0] Prdata,
  input  logic [NUM_SLV-1:0]        Pready,
  input  logic [NUM_SLV-1:0]        Pslverr
);
  localparam int SEL_W  = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
  localparam int MAX_SZ = $clog2(DATA_W / 8);
  typedef enum logic [2:0] {IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2} state_t;
  state_t state_q, state_d, state_new;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic [SEL_W-1:0]   idx_q, idx_d, hidx;
  logic [NUM_SLV-1:0] psel_q, psel_d;
  logic write_q, penable_q, valid, dec_err, done_ok, accept, unused_ok;
  assign unused_ok = ^{Hburst, Htrans[0]};
  assign valid     = Hreadyin && Htrans[1];
  assign hidx      = Haddr[SLV_SEL_LSB +: SEL_W];
  assign dec_err   = ({1'b0, hidx} >= (SEL_W + 1)'(NUM_SLV)) || (Hsize > 3'(MAX_SZ));
  assign done_ok   = state_q == ACCESS && Pready[idx_q] && !Pslverr[idx_q];
  // a new address phase is taken whenever the bridge is ready to the AHB side
  assign accept    = valid && (state_q == IDLE || state_q == ERR2 || done_ok);
  assign state_new = !valid ? IDLE : dec_err ? ERR1 : Hwrite ? WWAIT : SETUP;
  assign idx_d     = accept ? hidx : idx_q;
  assign psel_d    = (state_d == SETUP || state_d == ACCESS) ? NUM_SLV'(1) << idx_d : '0;
  always_ff @(posedge Hclk or posedge Hreset)
    if (Hreset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, ERR2: state_d = state_new;
      WWAIT:      state_d = SETUP;
      SETUP:      state_d = ACCESS;
      ACCESS:     state_d = !Pready[idx_q] ? ACCESS : Pslverr[idx_q] ? ERR1 : state_new;
      ERR1:       state_d = ERR2;
      default:    state_d = IDLE;
    endcase
  end
  always_comb begin
    Hreadyout = state_q == IDLE || state_q == ERR2 || done_ok;
    Hresp     = (state_q == ERR1 || state_q == ERR2) ? 2'b01 : 2'b00;
    Hrdata    = done_ok ? Prdata[idx_q*DATA_W +: DATA_W] : '0;
  end
  always_ff @(posedge Hclk or posedge Hreset)
    if (Hreset) begin
      addr_q    <= '0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      pwdata_q  <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= Haddr;
        write_q <= Hwrite;
      end
      idx_q <= idx_d;
      if (state_q == WWAIT) pwdata_q <= Hwdata;
      psel_q    <= psel_d;
      penable_q <= state_d == ACCESS;
    end
  assign Paddr   = addr_q;
  assign Pwrite  = write_q;
  assign Pwdata  = pwdata_q;
  assign Pselx   = psel_q;
  assign Penable = penable_q;
endmodule

// File: tb/tb_ahb_apb_bridge_mslv.sv
// tb_ahb_apb_bridge_mslv: directed scenarios for the AHB to APB bridge
module tb_ahb_apb_bridge_mslv;
  logic        Hclk = 1'b0, Hreset = 1'b1;
  logic [1:0]  Htrans = 2'b00;
  logic [2:0]  Hsize = 3'd2, Hburst = 3'd0;
  logic        Hreadyin = 1'b1, Hwrite = 1'b0;
  logic [31:0] Haddr = '0, Hwdata = '0;
  logic [31:0] Hrdata, Paddr, Pwdata;
  logic [1:0]  Hresp;
  logic        Hreadyout, Pwrite, Penable;
  logic [3:0]  Pselx;
  logic [127:0] Prdata = '0;
  logic [3:0]  Pready = 4'hF, Pslverr = 4'h0;
  logic [1:0]  Hresp3;
  logic        Hreadyout3;
  logic [2:0]  Pselx3;
  logic [31:0] unused_hrdata3, unused_paddr3, unused_pwdata3;
  logic        unused_pwrite3, unused_penable3;
  logic [95:0] Prdata3 = '0;
  logic [2:0]  Pready3 = 3'b111, Pslverr3 = 3'b000;
  int tests = 0, fails = 0;

  always #5 Hclk = ~Hclk;

  ahb_apb_bridge_mslv u_dut (
    .Hclk(Hclk), .Hreset(Hreset), .Htrans(Htrans), .Hsize(Hsize), .Hburst(Hburst),
    .Hreadyin(Hreadyin), .Haddr(Haddr), .Hwrite(Hwrite), .Hwdata(Hwdata),
    .Hrdata(Hrdata), .Hresp(Hresp), .Hreadyout(Hreadyout), .Paddr(Paddr),
    .Pwdata(Pwdata), .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr));

  ahb_apb_bridge_mslv #(.NUM_SLV(3)) u_dut3 (
    .Hclk(Hclk), .Hreset(Hreset), .Htrans(Htrans), .Hsize(Hsize), .Hburst(Hburst),
    .Hreadyin(Hreadyin), .Haddr(Haddr), .Hwrite(Hwrite), .Hwdata(Hwdata),
    .Hrdata(unused_hrdata3), .Hresp(Hresp3), .Hreadyout(Hreadyout3), .Paddr(unused_paddr3),
    .Pwdata(unused_pwdata3), .Pwrite(unused_pwrite3), .Pselx(Pselx3), .Penable(unused_penable3),
    .Prdata(Prdata3), .Pready(Pready3), .Pslverr(Pslverr3));

  task automatic nxt();
    @(posedge Hclk);
    #1;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz);
    Htrans = 2'b10; Haddr = a; Hwrite = w; Hsize = sz; Hreadyin = 1'b1;
  endtask

  task automatic test_reset();
    Hreset = 1'b1;
    nxt(); nxt();
    #1;
    tests++; if (Pselx !== 4'b0000) begin fails++; $display("FAIL rst_psel: got %b exp 0000", Pselx); end
    tests++; if (Penable !== 1'b0) begin fails++; $display("FAIL rst_penable: got %b exp 0", Penable); end
    tests++; if (Hreadyout !== 1'b1) begin fails++; $display("FAIL rst_hready: got %b exp 1", Hreadyout); end
    tests++; if (Hresp !== 2'b00) begin fails++; $display("FAIL rst_hresp: got %b exp 00", Hresp); end
    tests++; if (Hrdata !== 32'h0) begin fails++; $display("FAIL rst_hrdata: got %h exp 0", Hrdata); end
    tests++; if ({Paddr, Pwdata, Pwrite} !== 65'h0) begin fails++; $display("FAIL rst_apb: got %h/%h/%b exp 0", Paddr, Pwdata, Pwrite); end
    nxt();
    Hreset = 1'b0;
    nxt();
  endtask

  task automatic test_read();
    Prdata[64 +: 32] = 32'hCAFE_F00D;
    nxt(); addr_phase(32'h2000_0010, 1'b0, 3'd2); #1;
    tests++; if (Hreadyout !== 1'b1) begin fails++; $display("FAIL rd_idle_ready: got %b exp 1", Hreadyout); end
    nxt(); Htrans = 2'b00; #1;
    tests++; if (Pselx !== 4'b0100 || Penable !== 1'b0) begin fails++; $display("FAIL rd_setup: got psel %b en %b exp 0100 0", Pselx, Penable); end
    tests++; if (Hreadyout !== 1'b0) begin fails++; $display("FAIL rd_setup_ready: got %b exp 0", Hreadyout); end
    tests++; if (Paddr !== 32'h2000_0010 || Pwrite !== 1'b0) begin fails++; $display("FAIL rd_paddr: got %h %b exp 20000010 0", Paddr, Pwrite); end
    nxt(); #1;
    tests++; if (Pselx !== 4'b0100 || Penable !== 1'b1) begin fails++; $display("FAIL rd_access: got psel %b en %b exp 0100 1", Pselx, Penable); end
    tests++; if (Hreadyout !== 1'b1 || Hresp !== 2'b00) begin fails++; $display("FAIL rd_done: got rdy %b resp %b exp 1 00", Hreadyout, Hresp); end
    tests++; if (Hrdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL rd_data: got %h exp cafef00d", Hrdata); end
    nxt(); #1;
    tests++; if (Pselx !== 4'b0000 || Hrdata !== 32'h0) begin fails++; $display("FAIL rd_after: got psel %b data %h exp 0000 0", Pselx, Hrdata); end
  endtask

  task automatic test_write_wait();
    Pready[1] = 1'b0;
    nxt(); addr_phase(32'h1000_0004, 1'b1, 3'd2);
    nxt(); Htrans = 2'b00; Hwdata = 32'hA5A5_5A5A; #1;
    tests++; if (Hreadyout !== 1'b0 || Pselx !== 4'b0000) begin fails++; $display("FAIL wr_wwait: got rdy %b psel %b exp 0 0000", Hreadyout, Pselx); end
    nxt(); Hwdata = 32'h0; #1;
    tests++; if (Pselx !== 4'b0010 || Penable !== 1'b0 || Hreadyout !== 1'b0) begin fails++; $display("FAIL wr_setup: got psel %b en %b rdy %b exp 0010 0 0", Pselx, Penable, Hreadyout); end
    tests++; if (Pwdata !== 32'hA5A5_5A5A || Pwrite !== 1'b1) begin fails++; $display("FAIL wr_pwdata: got %h %b exp a5a55a5a 1", Pwdata, Pwrite); end
    for (int i = 0; i < 3; i++) begin
      nxt(); #1;
      tests++; if (Penable !== 1'b1 || Pselx !== 4'b0010 || Hreadyout !== 1'b0) begin fails++; $display("FAIL wr_wait%0d: got en %b psel %b rdy %b exp 1 0010 0", i, Penable, Pselx, Hreadyout); end
      tests++; if (Pwdata !== 32'hA5A5_5A5A || Paddr !== 32'h1000_0004) begin fails++; $display("FAIL wr_hold%0d: got %h %h exp a5a55a5a 10000004", i, Pwdata, Paddr); end
    end
    nxt(); Pready[1] = 1'b1; #1;
    tests++; if (Hreadyout !== 1'b1 || Hresp !== 2'b00) begin fails++; $display("FAIL wr_done: got rdy %b resp %b exp 1 00", Hreadyout, Hresp); end
    nxt(); #1;
    tests++; if (Pselx !== 4'b0000 || Penable !== 1'b0) begin fails++; $display("FAIL wr_after: got psel %b en %b exp 0000 0", Pselx, Penable); end
  endtask

  task automatic test_slverr();
    Pslverr[3] = 1'b1;
    nxt(); addr_phase(32'h3000_0000, 1'b0, 3'd2);
    nxt(); Htrans = 2'b00;
    nxt(); #1;
    tests++; if (Hreadyout !== 1'b0 || Hresp !== 2'b00 || Pselx !== 4'b1000) begin fails++; $display("FAIL se_access: got rdy %b resp %b psel %b exp 0 00 1000", Hreadyout, Hresp, Pselx); end
    nxt(); #1;
    tests++; if (Hresp !== 2'b01 || Hreadyout !== 1'b0 || Pselx !== 4'b0000) begin fails++; $display("FAIL se_err1: got resp %b rdy %b psel %b exp 01 0 0000", Hresp, Hreadyout, Pselx); end
    nxt(); #1;
    tests++; if (Hresp !== 2'b01 || Hreadyout !== 1'b1 || Pselx !== 4'b0000) begin fails++; $display("FAIL se_err2: got resp %b rdy %b psel %b exp 01 1 0000", Hresp, Hreadyout, Pselx); end
    nxt(); Pslverr[3] = 1'b0; #1;
    tests++; if (Hresp !== 2'b00 || Hreadyout !== 1'b1) begin fails++; $display("FAIL se_after: got resp %b rdy %b exp 00 1", Hresp, Hreadyout); end
  endtask

  task automatic test_decode_err();
    nxt(); addr_phase(32'h3000_0000, 1'b0, 3'd2);
    nxt(); Htrans = 2'b00; #1;
    tests++; if (Hresp3 !== 2'b01 || Hreadyout3 !== 1'b0 || Pselx3 !== 3'b000) begin fails++; $display("FAIL dec_idx_err1: got resp %b rdy %b psel %b exp 01 0 000", Hresp3, Hreadyout3, Pselx3); end
    nxt(); #1;
    tests++; if (Hresp3 !== 2'b01 || Hreadyout3 !== 1'b1 || Pselx3 !== 3'b000) begin fails++; $display("FAIL dec_idx_err2: got resp %b rdy %b psel %b exp 01 1 000", Hresp3, Hreadyout3, Pselx3); end
    nxt(); nxt();
    addr_phase(32'h0000_0000, 1'b0, 3'd3);
    nxt(); Htrans = 2'b00; Hsize = 3'd2; #1;
    tests++; if (Hresp !== 2'b01 || Hreadyout !== 1'b0 || Pselx !== 4'b0000) begin fails++; $display("FAIL dec_size_err1: got resp %b rdy %b psel %b exp 01 0 0000", Hresp, Hreadyout, Pselx); end
    nxt(); #1;
    tests++; if (Hresp !== 2'b01 || Hreadyout !== 1'b1 || Pselx !== 4'b0000) begin fails++; $display("FAIL dec_size_err2: got resp %b rdy %b psel %b exp 01 1 0000", Hresp, Hreadyout, Pselx); end
    nxt(); #1;
    tests++; if (Hresp !== 2'b00 || Pselx !== 4'b0000) begin fails++; $display("FAIL dec_after: got resp %b psel %b exp 00 0000", Hresp, Pselx); end
  endtask

  task automatic test_back_to_back();
    Prdata[0 +: 32] = 32'h1234_5678;
    nxt(); addr_phase(32'h0000_0008, 1'b0, 3'd2);
    nxt(); Htrans = 2'b00;
    nxt(); addr_phase(32'h1000_0020, 1'b1, 3'd2); #1;
    tests++; if (Hreadyout !== 1'b1 || Hrdata !== 32'h1234_5678 || Hresp !== 2'b00) begin fails++; $display("FAIL b2b_rd: got rdy %b data %h resp %b exp 1 12345678 00", Hreadyout, Hrdata, Hresp); end
    nxt(); Htrans = 2'b00; Hwdata = 32'h0BAD_BEEF; #1;
    tests++; if (Hreadyout !== 1'b0 || Pselx !== 4'b0000) begin fails++; $display("FAIL b2b_wwait: got rdy %b psel %b exp 0 0000", Hreadyout, Pselx); end
    nxt(); Hwdata = 32'h0; #1;
    tests++; if (Pselx !== 4'b0010 || Paddr !== 32'h1000_0020 || Pwdata !== 32'h0BAD_BEEF) begin fails++; $display("FAIL b2b_setup: got psel %b addr %h wd %h exp 0010 10000020 0badbeef", Pselx, Paddr, Pwdata); end
    nxt(); #1;
    tests++; if (Hreadyout !== 1'b1 || Hresp !== 2'b00 || Penable !== 1'b1) begin fails++; $display("FAIL b2b_wr: got rdy %b resp %b en %b exp 1 00 1", Hreadyout, Hresp, Penable); end
    nxt();
  endtask

  task automatic test_reset_mid();
    Pready[1] = 1'b0;
    nxt(); addr_phase(32'h1000_0000, 1'b0, 3'd2);
    nxt(); Htrans = 2'b00;
    nxt(); #1;
    tests++; if (Penable !== 1'b1 || Hreadyout !== 1'b0) begin fails++; $display("FAIL rm_access: got en %b rdy %b exp 1 0", Penable, Hreadyout); end
    Hreset = 1'b1; #1;
    tests++; if (Pselx !== 4'b0000 || Penable !== 1'b0) begin fails++; $display("FAIL rm_apb: got psel %b en %b exp 0000 0", Pselx, Penable); end
    tests++; if (Hresp !== 2'b00 || Hreadyout !== 1'b1) begin fails++; $display("FAIL rm_ahb: got resp %b rdy %b exp 00 1", Hresp, Hreadyout); end
    nxt(); Hreset = 1'b0; Pready[1] = 1'b1;
    nxt(); addr_phase(32'h2000_0000, 1'b0, 3'd2);
    nxt(); Htrans = 2'b00;
    nxt(); #1;
    tests++; if (Hreadyout !== 1'b1 || Hrdata !== 32'hCAFE_F00D || Hresp !== 2'b00) begin fails++; $display("FAIL rm_reread: got rdy %b data %h resp %b exp 1 cafef00d 00", Hreadyout, Hrdata, Hresp); end
    nxt();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_wait();
    test_slverr();
    test_decode_err();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
